// File: rtl/jedro_1_defines.sv
// Shared encodings for the jedro_1 RV32I core: opcodes, funct fields and ALU operations.
package jedro_1_defines;

   localparam int REG_ADDR_W = 5;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_SLL,
      ALU_SLT,
      ALU_SLTU,
      ALU_XOR,
      ALU_SRL,
      ALU_SRA,
      ALU_OR,
      ALU_AND
   } alu_op_e;

endpackage

// File: rtl/jedro_1_regfile.sv
// 32x32 integer register file: two combinational read ports, one synchronous write port, x0 hardwired to zero.
module jedro_1_regfile
   import jedro_1_defines::*;
(
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic [REG_ADDR_W-1:0] rs1_addr_i,
   input  logic [REG_ADDR_W-1:0] rs2_addr_i,
   output logic [31:0]           rs1_data_o,
   output logic [31:0]           rs2_data_o,
   input  logic                  we_i,
   input  logic [REG_ADDR_W-1:0] rd_addr_i,
   input  logic [31:0]           rd_data_i
);

   logic [31:0] regfile [31:0];

   // NOTE: the whole array is reset because software may read any register before writing it;
   // this forces flops rather than a RAM macro, which is acceptable at 32 entries.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < 32; i++) regfile[i] <= '0;
      end else if (we_i && (rd_addr_i != '0)) begin
         regfile[rd_addr_i] <= rd_data_i;
      end
   end

   assign rs1_data_o = (rs1_addr_i == '0) ? '0 : regfile[rs1_addr_i];
   assign rs2_data_o = (rs2_addr_i == '0) ? '0 : regfile[rs2_addr_i];

endmodule

// File: rtl/jedro_1_core_top.sv
// Minimal two-stage RV32I core: fetch from a synchronous ROM, decode/execute/writeback in the next cycle.
module jedro_1_core_top
   import jedro_1_defines::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = 32'h0000_0000
)(
   input  logic                  clk_i,
   input  logic                  rstn_i,
   output logic [ADDR_WIDTH-1:0] instr_mem_addr_o,
   input  logic [DATA_WIDTH-1:0] instr_mem_rdata_i,
   output logic [ADDR_WIDTH-1:0] data_mem_addr_o,
   output logic [DATA_WIDTH-1:0] data_mem_wdata_o,
   output logic [3:0]            data_mem_we_o,
   input  logic [DATA_WIDTH-1:0] data_mem_rdata_i
);

   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] exec_pc;
   logic                  instr_valid;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         pc          <= BOOT_ADDR;
         exec_pc     <= BOOT_ADDR;
         instr_valid <= 1'b0;
      end else begin
         exec_pc     <= pc;
         pc          <= pc + ADDR_WIDTH'(4);
         instr_valid <= 1'b1;
      end
   end

   assign instr_mem_addr_o = pc;

   // The word on instr_mem_rdata_i was fetched from exec_pc one cycle earlier.
   logic [31:0]           instr;
   logic [6:0]            opcode;
   logic [2:0]            funct3;
   logic [6:0]            funct7;
   logic [REG_ADDR_W-1:0] rd_addr;
   logic [REG_ADDR_W-1:0] rs1_addr;
   logic [REG_ADDR_W-1:0] rs2_addr;
   logic [31:0]           imm_i;
   logic [31:0]           imm_u;
   logic [31:0]           rs1_data;
   logic [31:0]           rs2_data;

   assign instr    = instr_mem_rdata_i;
   assign opcode   = instr[6:0];
   assign rd_addr  = instr[11:7];
   assign funct3   = instr[14:12];
   assign rs1_addr = instr[19:15];
   assign rs2_addr = instr[24:20];
   assign funct7   = instr[31:25];
   assign imm_i    = {{20{instr[31]}}, instr[31:20]};
   assign imm_u    = {instr[31:12], 12'b0};

   alu_op_e     alu_op;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        legal;

   // NOTE: every output gets a default before the case, so no path leaves a signal unassigned (no latch).
   always_comb begin
      alu_op = ALU_ADD;
      op_a   = rs1_data;
      op_b   = imm_i;
      legal  = 1'b0;
      case (opcode)
         OPC_OP_IMM: begin
            legal = 1'b1;
            case (funct3)
               F3_ADD_SUB: alu_op = ALU_ADD;
               F3_SLT:     alu_op = ALU_SLT;
               F3_SLTU:    alu_op = ALU_SLTU;
               F3_XOR:     alu_op = ALU_XOR;
               F3_OR:      alu_op = ALU_OR;
               F3_AND:     alu_op = ALU_AND;
               F3_SLL: begin
                  alu_op = ALU_SLL;
                  legal  = (funct7 == F7_BASE);
               end
               F3_SRL_SRA: begin
                  alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                  legal  = (funct7 == F7_BASE) || (funct7 == F7_ALT);
               end
               default: legal = 1'b0;
            endcase
         end
         OPC_OP: begin
            op_b  = rs2_data;
            legal = (funct7 == F7_BASE) ||
                    ((funct7 == F7_ALT) && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA)));
            case (funct3)
               F3_ADD_SUB: alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
               F3_SLL:     alu_op = ALU_SLL;
               F3_SLT:     alu_op = ALU_SLT;
               F3_SLTU:    alu_op = ALU_SLTU;
               F3_XOR:     alu_op = ALU_XOR;
               F3_SRL_SRA: alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
               F3_OR:      alu_op = ALU_OR;
               F3_AND:     alu_op = ALU_AND;
               default:    alu_op = ALU_ADD;
            endcase
         end
         OPC_LUI: begin
            legal = 1'b1;
            op_a  = '0;
            op_b  = imm_u;
         end
         OPC_AUIPC: begin
            legal = 1'b1;
            op_a  = exec_pc;
            op_b  = imm_u;
         end
         default: legal = 1'b0;
      endcase
   end

   logic [31:0] alu_result;
   logic [4:0]  shamt;

   assign shamt = op_b[4:0];

   always_comb begin
      alu_result = '0;
      case (alu_op)
         ALU_ADD:  alu_result = op_a + op_b;
         ALU_SUB:  alu_result = op_a - op_b;
         ALU_SLL:  alu_result = op_a << shamt;
         ALU_SLT:  alu_result = {31'b0, $signed(op_a) < $signed(op_b)};
         ALU_SLTU: alu_result = {31'b0, op_a < op_b};
         ALU_XOR:  alu_result = op_a ^ op_b;
         ALU_SRL:  alu_result = op_a >> shamt;
         ALU_SRA:  alu_result = $unsigned($signed(op_a) >>> shamt);
         ALU_OR:   alu_result = op_a | op_b;
         ALU_AND:  alu_result = op_a & op_b;
         default:  alu_result = '0;
      endcase
   end

   jedro_1_regfile regfile_inst (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .rs1_addr_i (rs1_addr),
      .rs2_addr_i (rs2_addr),
      .rs1_data_o (rs1_data),
      .rs2_data_o (rs2_data),
      .we_i       (instr_valid && legal),
      .rd_addr_i  (rd_addr),
      .rd_data_i  (alu_result)
   );

   // Data bus is wired but idle until load/store support lands.
   assign data_mem_addr_o  = '0;
   assign data_mem_wdata_o = '0;
   assign data_mem_we_o    = '0;

   logic unused_rdata;
   assign unused_rdata = ^data_mem_rdata_i;

endmodule

// File: tb/tb_jedro_1_core_top.sv
// Self-checking bench for jedro_1_core_top: directed programs plus random ALU programs against an ISS model.
module tb_jedro_1_core_top;

   logic        clk_i = 1'b0;
   logic        rstn_i = 1'b0;
   logic [31:0] instr_mem_addr_o;
   logic [31:0] instr_mem_rdata_i = '0;
   logic [31:0] data_mem_addr_o;
   logic [31:0] data_mem_wdata_o;
   logic [3:0]  data_mem_we_o;
   logic [31:0] data_mem_rdata_i = 32'hDEAD_BEEF;

   int checks = 0;
   int errors = 0;
   int bus_bad = 0;

   logic [31:0] rom [0:255];
   logic [31:0] ref_regs [0:31];

   jedro_1_core_top dut (
      .clk_i             (clk_i),
      .rstn_i            (rstn_i),
      .instr_mem_addr_o  (instr_mem_addr_o),
      .instr_mem_rdata_i (instr_mem_rdata_i),
      .data_mem_addr_o   (data_mem_addr_o),
      .data_mem_wdata_o  (data_mem_wdata_o),
      .data_mem_we_o     (data_mem_we_o),
      .data_mem_rdata_i  (data_mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   // Synchronous-read instruction ROM
   always @(posedge clk_i) instr_mem_rdata_i <= rom[instr_mem_addr_o[9:2]];

   always @(negedge clk_i)
      if (data_mem_addr_o !== '0 || data_mem_wdata_o !== '0 || data_mem_we_o !== '0) bus_bad++;

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
      return {imm, rs1, f3, rd, opc};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] opc);
      return {imm, rd, opc};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 9))
         0, 1, 2: w[6:0] = 7'h13;
         3, 4, 5: w[6:0] = 7'h33;
         6:       w[6:0] = 7'h37;
         7:       w[6:0] = 7'h17;
         8:       ;
         default: w = '0;
      endcase
      if (w[6:0] == 7'h13 || w[6:0] == 7'h33) begin
         case ($urandom_range(0, 3))
            0, 1:    w[31:25] = 7'h00;
            2:       w[31:25] = 7'h20;
            default: ;
         endcase
      end
      return w;
   endfunction

   // Instruction-set model: runs n instructions from address 0 over the ROM image.
   task automatic model_run(input int n);
      logic [31:0] mpc;
      mpc = '0;
      for (int i = 0; i < 32; i++) ref_regs[i] = '0;
      for (int k = 0; k < n; k++) begin
         logic [31:0] ins, a, b, immi, res;
         logic [2:0]  f3;
         logic [6:0]  f7;
         logic [4:0]  sh;
         bit          wr;
         ins  = rom[mpc[9:2]];
         a    = ref_regs[ins[19:15]];
         b    = ref_regs[ins[24:20]];
         immi = {{20{ins[31]}}, ins[31:20]};
         f3   = ins[14:12];
         f7   = ins[31:25];
         res  = '0;
         wr   = 1'b0;
         case (ins[6:0])
            7'h13: begin
               sh = ins[24:20];
               wr = 1'b1;
               case (f3)
                  3'd0: res = a + immi;
                  3'd2: res = ($signed(a) < $signed(immi)) ? 32'd1 : 32'd0;
                  3'd3: res = (a < immi) ? 32'd1 : 32'd0;
                  3'd4: res = a ^ immi;
                  3'd6: res = a | immi;
                  3'd7: res = a & immi;
                  3'd1: begin res = a << sh; wr = (f7 == 7'h00); end
                  default: begin
                     if (f7 == 7'h20) res = $unsigned($signed(a) >>> sh);
                     else res = a >> sh;
                     wr = (f7 == 7'h00) || (f7 == 7'h20);
                  end
               endcase
            end
            7'h33: begin
               sh = b[4:0];
               wr = 1'b1;
               if (f7 == 7'h00) begin
                  case (f3)
                     3'd0: res = a + b;
                     3'd1: res = a << sh;
                     3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                     3'd3: res = (a < b) ? 32'd1 : 32'd0;
                     3'd4: res = a ^ b;
                     3'd5: res = a >> sh;
                     3'd6: res = a | b;
                     default: res = a & b;
                  endcase
               end else if (f7 == 7'h20 && f3 == 3'd0) res = a - b;
               else if (f7 == 7'h20 && f3 == 3'd5) res = $unsigned($signed(a) >>> sh);
               else wr = 1'b0;
            end
            7'h37: begin res = {ins[31:12], 12'h000}; wr = 1'b1; end
            7'h17: begin res = mpc + {ins[31:12], 12'h000}; wr = 1'b1; end
            default: wr = 1'b0;
         endcase
         if (wr && ins[11:7] != 5'd0) ref_regs[ins[11:7]] = res;
         mpc = mpc + 32'd4;
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = '0;
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk_i);
      rstn_i = 1'b0;
      repeat (cycles) @(negedge clk_i);
      rstn_i = 1'b1;
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic test_ori();
      clear_rom();
      rom[0] = enc_i(12'd1024, 5'd0, 3'd0, 5'd5, 7'h13);
      rom[1] = enc_i(12'd31, 5'd5, 3'd6, 5'd6, 7'h13);
      do_reset(3);
      run(32);
      for (int i = 0; i < 32; i++) begin
         logic [31:0] exp;
         exp = (i == 5) ? 32'd1024 : (i == 6) ? 32'd1055 : 32'd0;
         checks++;
         if (dut.regfile_inst.regfile[i] !== exp) begin
            errors++;
            $display("FAIL ori x%0d got %h expected %h", i, dut.regfile_inst.regfile[i], exp);
         end
      end
   endtask

   task automatic test_reset();
      // Registers and PC are non-zero from the previous program; reset must clear them at once.
      @(negedge clk_i);
      rstn_i = 1'b0;
      #1;
      checks++;
      if (instr_mem_addr_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_async_pc got %h expected %h", instr_mem_addr_o, 32'h0);
      end
      checks++;
      if (dut.regfile_inst.regfile[6] !== 32'h0) begin
         errors++;
         $display("FAIL reset_async_x6 got %h expected %h", dut.regfile_inst.regfile[6], 32'h0);
      end
      repeat (3) @(negedge clk_i);
      checks++;
      if (instr_mem_addr_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_hold_pc got %h expected %h", instr_mem_addr_o, 32'h0);
      end
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (dut.regfile_inst.regfile[i] !== 32'h0) begin
            errors++;
            $display("FAIL reset_reg x%0d got %h expected 0", i, dut.regfile_inst.regfile[i]);
         end
      end
      rstn_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (instr_mem_addr_o !== 32'(4 * i)) begin
            errors++;
            $display("FAIL fetch_step %0d got %h expected %h", i, instr_mem_addr_o, 32'(4 * i));
         end
         @(negedge clk_i);
      end
   endtask

   task automatic test_x0();
      clear_rom();
      rom[0] = enc_i(12'd9, 5'd0, 3'd0, 5'd7, 7'h13);
      rom[1] = enc_i(12'd5, 5'd0, 3'd0, 5'd0, 7'h13);
      rom[2] = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd7);
      do_reset(2);
      run(8);
      checks++;
      if (dut.regfile_inst.regfile[0] !== 32'h0) begin
         errors++;
         $display("FAIL x0_write got %h expected 0", dut.regfile_inst.regfile[0]);
      end
      checks++;
      if (dut.regfile_inst.regfile[7] !== 32'h0) begin
         errors++;
         $display("FAIL x0_read x7 got %h expected 0", dut.regfile_inst.regfile[7]);
      end
   endtask

   task automatic test_signed();
      logic [31:0] exp [0:4];
      int          idx [0:4];
      clear_rom();
      rom[0] = enc_i(12'hFFF, 5'd0, 3'd0, 5'd1, 7'h13);
      rom[1] = enc_i(12'd1, 5'd1, 3'd3, 5'd2, 7'h13);
      rom[2] = enc_i(12'd0, 5'd1, 3'd2, 5'd3, 7'h13);
      rom[3] = enc_i(12'h404, 5'd1, 3'd5, 5'd4, 7'h13);
      rom[4] = enc_i(12'd28, 5'd1, 3'd5, 5'd8, 7'h13);
      idx = '{1, 2, 3, 4, 8};
      exp = '{32'hFFFF_FFFF, 32'h0, 32'h1, 32'hFFFF_FFFF, 32'hF};
      do_reset(2);
      run(10);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (dut.regfile_inst.regfile[idx[i]] !== exp[i]) begin
            errors++;
            $display("FAIL signed x%0d got %h expected %h", idx[i], dut.regfile_inst.regfile[idx[i]], exp[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      clear_rom();
      rom[0] = enc_i(12'd7, 5'd0, 3'd0, 5'd1, 7'h13);
      rom[1] = enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2);
      rom[2] = enc_r(7'h20, 5'd2, 5'd0, 3'd0, 5'd3);
      do_reset(2);
      run(6);
      checks++;
      if (dut.regfile_inst.regfile[2] !== 32'd14) begin
         errors++;
         $display("FAIL b2b x2 got %h expected %h", dut.regfile_inst.regfile[2], 32'd14);
      end
      checks++;
      if (dut.regfile_inst.regfile[3] !== 32'hFFFF_FFF2) begin
         errors++;
         $display("FAIL b2b x3 got %h expected %h", dut.regfile_inst.regfile[3], 32'hFFFF_FFF2);
      end
   endtask

   task automatic test_lui_auipc();
      clear_rom();
      rom[0] = enc_u(20'h12345, 5'd9, 7'h37);
      rom[1] = enc_u(20'h00001, 5'd10, 7'h17);
      do_reset(2);
      run(6);
      checks++;
      if (dut.regfile_inst.regfile[9] !== 32'h1234_5000) begin
         errors++;
         $display("FAIL lui x9 got %h expected %h", dut.regfile_inst.regfile[9], 32'h1234_5000);
      end
      checks++;
      if (dut.regfile_inst.regfile[10] !== 32'h0000_1004) begin
         errors++;
         $display("FAIL auipc x10 got %h expected %h", dut.regfile_inst.regfile[10], 32'h0000_1004);
      end
      checks++;
      if (bus_bad !== 0) begin
         errors++;
         $display("FAIL data_bus_idle nonzero cycles %0d expected 0", bus_bad);
      end
   endtask

   task automatic test_random(input int rounds);
      for (int r = 0; r < rounds; r++) begin
         clear_rom();
         for (int i = 0; i < 40; i++) rom[i] = rand_instr();
         do_reset(2);
         run(48);
         model_run(47);
         for (int i = 0; i < 32; i++) begin
            checks++;
            if (dut.regfile_inst.regfile[i] !== ref_regs[i]) begin
               errors++;
               $display("FAIL random r%0d x%0d got %h expected %h", r, i, dut.regfile_inst.regfile[i], ref_regs[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_run();
      clear_rom();
      for (int i = 0; i < 40; i++) rom[i] = rand_instr();
      rom[0] = enc_i(12'd77, 5'd0, 3'd0, 5'd11, 7'h13);
      do_reset(2);
      repeat ($urandom_range(5, 15)) @(posedge clk_i);
      #2;
      rstn_i = 1'b0;
      #1;
      checks++;
      if (instr_mem_addr_o !== 32'h0) begin
         errors++;
         $display("FAIL midrun_pc got %h expected %h", instr_mem_addr_o, 32'h0);
      end
      checks++;
      if (dut.regfile_inst.regfile[11] !== 32'h0) begin
         errors++;
         $display("FAIL midrun_x11 got %h expected 0", dut.regfile_inst.regfile[11]);
      end
      @(negedge clk_i);
      @(negedge clk_i);
      rstn_i = 1'b1;
      run(48);
      model_run(47);
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (dut.regfile_inst.regfile[i] !== ref_regs[i]) begin
            errors++;
            $display("FAIL midrun_rerun x%0d got %h expected %h", i, dut.regfile_inst.regfile[i], ref_regs[i]);
         end
      end
   endtask

   initial begin
      clear_rom();
      test_ori();
      test_reset();
      test_x0();
      test_signed();
      test_back_to_back();
      test_lui_auipc();
      test_random(4);
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
